game_flow_controller: RTL
=========================

Name: game_flow_controller

Overview:
- Top-level sequencer for the Pac-Man game-logic datapath: IDLE → READY → PLAY → DYING / LEVEL_CLEAR → GAME_OVER.
- Owns lives, level and the eaten-food count.
- Generates the per-frame move enables for pacman and the ghosts, plus the sprite-reset and score-clear pulses that drive the position/score registers.
- Sits between the input/collision logic and the position-update instances; replaces their free-running divided clocks with enables.

Parameters:
- LIVES, 3, lives at game start (1..7).
- READY_FRAMES, 120, frame_ticks spent in READY before PLAY.
- DYING_FRAMES, 90, frame_ticks spent in DYING.
- CLEAR_FRAMES, 60, frame_ticks spent in LEVEL_CLEAR.
- PACMAN_DIV, 2, frame_ticks per pacman move (≥1).
- GHOST_DIV, 4, frame_ticks per ghost move at level 0 (≥1).
- FOOD_TOTAL, 12'd1000, pellets per level (1..4095).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- frame_tick  in  1  one-cycle pulse per video frame.
- start_btn  in  1  level-sensitive start request.
- pacman_is_dead  in  1  OR of ghost collisions.
- food_eaten  in  1  one-cycle pulse per pellet consumed.
- state  out  3  IDLE=0, READY=1, PLAY=2, DYING=3, LEVEL_CLEAR=4, GAME_OVER=5.
- pacman_move_en  out  1  one-cycle enable to pacman position update.
- ghost_move_en  out  1  one-cycle enable to all ghost position/control updates.
- sprite_reset  out  1  one-cycle pulse: reload all sprite reset positions and previous directions.
- score_clear  out  1  one-cycle pulse: zero total score.
- lives_left  out  3  remaining lives.
- level  out  4  current level, 0..15.
- food_count  out  12  pellets eaten this level.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, lives_left=LIVES, level=0, food_count=0.
  - All pulse outputs 0; frame and divider counters 0.
- All outputs are registered. Pulses are exactly one clk wide.
- IDLE: start_btn=1 → READY next cycle. Same edge: score_clear=1, sprite_reset=1, lives_left=LIVES, level=0, food_count=0.
- READY:
  - Frame counter increments on each frame_tick.
  - On the READY_FRAMES-th tick → PLAY; frame counter and both move dividers cleared.
- PLAY move dividers:
  - Pacman divider counts frame_ticks 0..PACMAN_DIV-1. pacman_move_en pulses on the clk after the tick where the divider wraps.
  - Ghost divider period is eff_gdiv = max(GHOST_DIV − level, 1). ghost_move_en is generated the same way.
  - Both enables may assert in the same cycle.
- PLAY food counting:
  - food_eaten increments food_count, saturating at 4095.
  - When food_count reaches FOOD_TOTAL → LEVEL_CLEAR.
- PLAY death:
  - pacman_is_dead=1 → DYING. lives_left decrements on the transition edge; floor 0.
  - Death wins over food: if pacman_is_dead and food_eaten are high in the same cycle, the food pulse is ignored.
- Move enables are 0 in every state except PLAY.
- DYING:
  - After DYING_FRAMES ticks: lives_left=0 → GAME_OVER; otherwise → READY with sprite_reset=1.
  - food_count and score are kept.
- LEVEL_CLEAR: after CLEAR_FRAMES ticks → READY with sprite_reset=1, food_count=0, level+1 saturating at 15.
- GAME_OVER: holds until start_btn=1, then behaves exactly as the IDLE exit (new game).
- frame_tick during a transition cycle counts toward the new state only from the following tick.
- pacman_is_dead outside PLAY is ignored.
- start_btn outside IDLE/GAME_OVER is ignored.
- Reset asserted mid-operation aborts immediately to IDLE with no pulses emitted.

Test Plan:
- Setup: READY_FRAMES=4, DYING_FRAMES=2, CLEAR_FRAMES=2, FOOD_TOTAL=5. Release rst, start_btn=1 → state 0→1; score_clear and sprite_reset single pulses; lives_left=3; PLAY after the 4th frame_tick.
- PLAY, PACMAN_DIV=2, GHOST_DIV=4, level 0, 8 frame_ticks → 4 pacman_move_en pulses and 2 ghost_move_en pulses; coincident enables on ticks 4 and 8.
- 5 food_eaten pulses → food_count=5, LEVEL_CLEAR; 2 ticks later READY with level=1, food_count=0. Next PLAY gives ghost period 3.
- pacman_is_dead with food_eaten in the same cycle at food_count=4 → DYING, lives_left=2, food_count stays 4; after 2 ticks READY with sprite_reset.
- Three deaths → GAME_OVER with lives_left=0. start_btn → READY with lives_left=3 and score_clear pulse.
- Drive rst low during DYING, mid-frame → state=0, all pulses 0, lives_left=3, level=0 asynchronously.

Source files
------------

// File: rtl/game_flow_controller.sv
// Top-level Pac-Man game sequencer: owns lives, level and food count, and turns
// frame ticks into per-frame move enables and sprite/score reset pulses.
module game_flow_controller #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned READY_FRAMES = 120,
  parameter int unsigned DYING_FRAMES = 90,
  parameter int unsigned CLEAR_FRAMES = 60,
  parameter int unsigned PACMAN_DIV   = 2,
  parameter int unsigned GHOST_DIV    = 4,
  parameter logic [11:0] FOOD_TOTAL   = 12'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        pacman_is_dead,
  input  logic        food_eaten,
  output logic [2:0]  state,
  output logic        pacman_move_en,
  output logic        ghost_move_en,
  output logic        sprite_reset,
  output logic        score_clear,
  output logic [2:0]  lives_left,
  output logic [3:0]  level,
  output logic [11:0] food_count
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_READY       = 3'd1,
    S_PLAY        = 3'd2,
    S_DYING       = 3'd3,
    S_LEVEL_CLEAR = 3'd4,
    S_GAME_OVER   = 3'd5
  } state_e;

  localparam int CW = 16;
  localparam logic [CW-1:0] READY_LAST = CW'(READY_FRAMES - 1);
  localparam logic [CW-1:0] DYING_LAST = CW'(DYING_FRAMES - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_FRAMES - 1);
  localparam logic [CW-1:0] PAC_LAST   = CW'(PACMAN_DIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] pac_cnt_q, pac_cnt_d;
  logic [CW-1:0] ghost_cnt_q, ghost_cnt_d;
  logic [CW-1:0] ghost_last;
  logic [2:0]    lives_d;
  logic [3:0]    level_d;
  logic [11:0]   food_d, food_inc;
  logic          pac_en_d, ghost_en_d, sprite_reset_d, score_clear_d;

  // Ghosts speed up one frame per level until they move every frame.
  always_comb begin
    ghost_last = '0;
    if (GHOST_DIV > 32'(level) + 32'd1)
      ghost_last = CW'(GHOST_DIV - 32'(level) - 32'd1);
  end

  assign food_inc = (food_count == 12'hFFF) ? food_count : food_count + 12'd1;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    pac_cnt_d      = pac_cnt_q;
    ghost_cnt_d    = ghost_cnt_q;
    lives_d        = lives_left;
    level_d        = level;
    food_d         = food_count;
    pac_en_d       = 1'b0;
    ghost_en_d     = 1'b0;
    sprite_reset_d = 1'b0;
    score_clear_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_btn) begin
          state_d        = S_READY;
          frame_cnt_d    = '0;
          lives_d        = 3'(LIVES);
          level_d        = 4'd0;
          food_d         = 12'd0;
          sprite_reset_d = 1'b1;
          score_clear_d  = 1'b1;
        end
      end
      S_READY: begin
        if (frame_tick) begin
          if (frame_cnt_q == READY_LAST) begin
            state_d     = S_PLAY;
            frame_cnt_d = '0;
            pac_cnt_d   = '0;
            ghost_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
      S_PLAY: begin
        if (pacman_is_dead) begin
          state_d     = S_DYING;
          frame_cnt_d = '0;
          lives_d     = (lives_left == 3'd0) ? 3'd0 : lives_left - 3'd1;
        end else if (food_eaten && food_inc >= FOOD_TOTAL) begin
          state_d     = S_LEVEL_CLEAR;
          frame_cnt_d = '0;
          food_d      = food_inc;
        end else begin
          if (food_eaten) food_d = food_inc;
          // Enables only fire while the game stays in PLAY.
          if (frame_tick) begin
            if (pac_cnt_q >= PAC_LAST) begin
              pac_cnt_d = '0;
              pac_en_d  = 1'b1;
            end else begin
              pac_cnt_d = pac_cnt_q + CW'(1);
            end
            if (ghost_cnt_q >= ghost_last) begin
              ghost_cnt_d = '0;
              ghost_en_d  = 1'b1;
            end else begin
              ghost_cnt_d = ghost_cnt_q + CW'(1);
            end
          end
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (frame_cnt_q == DYING_LAST) begin
            frame_cnt_d = '0;
            if (lives_left == 3'd0) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d        = S_READY;
              sprite_reset_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
      S_LEVEL_CLEAR: begin
        if (frame_tick) begin
          if (frame_cnt_q == CLEAR_LAST) begin
            state_d        = S_READY;
            frame_cnt_d    = '0;
            food_d         = 12'd0;
            level_d        = (level == 4'd15) ? 4'd15 : level + 4'd1;
            sprite_reset_d = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      frame_cnt_q    <= '0;
      pac_cnt_q      <= '0;
      ghost_cnt_q    <= '0;
      lives_left     <= 3'(LIVES);
      level          <= 4'd0;
      food_count     <= 12'd0;
      pacman_move_en <= 1'b0;
      ghost_move_en  <= 1'b0;
      sprite_reset   <= 1'b0;
      score_clear    <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      pac_cnt_q      <= pac_cnt_d;
      ghost_cnt_q    <= ghost_cnt_d;
      lives_left     <= lives_d;
      level          <= level_d;
      food_count     <= food_d;
      pacman_move_en <= pac_en_d;
      ghost_move_en  <= ghost_en_d;
      sprite_reset   <= sprite_reset_d;
      score_clear    <= score_clear_d;
    end
  end

  assign state = state_q;

endmodule
